fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the `cpu` decode/execute datapath.
- Owns the 8-bit program counter and drives the synchronous 256×8 instruction memory.
- Buffers returned instruction bytes, each paired with its PC, in a 2-entry queue, and presents them to decode over a valid/ready handshake.
- Accepts branch/jump redirects from execute, which flush all buffered and in-flight fetches.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/fetch_unit_if.sv | 34 +++
 rtl/fetch_queue.sv | 41 ++++
 rtl/fetch_unit.sv | 108 ++++++++++
 tb/tb_fetch_unit.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch/decode types: widths, HALT opcode, queue entry layout and fetch FSM encoding.
package cpu_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  localparam logic [3:0] OPCODE_HALT = 4'hF;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    FETCH_RUN  = 1'b0,
    FETCH_HALT = 1'b1
  } fetch_state_t;

  function automatic logic is_halt(input logic [DATA_W-1:0] instr);
    return instr[DATA_W-1 -: 4] == OPCODE_HALT;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch bus: instruction-memory port, redirect from execute, and the decode handshake.
interface fetch_unit_if;
  import cpu_pkg::*;

  logic              imem_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              halted;

  modport master (
    output imem_en, imem_addr,
    input  imem_rdata,
    input  redirect_valid, redirect_pc,
    output instr, instr_pc, instr_valid,
    input  instr_ready,
    output halted
  );

  modport slave (
    input  imem_en, imem_addr,
    output imem_rdata,
    output redirect_valid, redirect_pc,
    input  instr, instr_pc, instr_valid,
    output instr_ready,
    input  halted
  );

endinterface

// File: rtl/fetch_queue.sv
// Two-entry FIFO of {pc, instr} pairs with push, pop, flush and occupancy count.
module fetch_queue
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_entry,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t slot [2];
  logic         rd_ptr;
  logic         wr_ptr;

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      count   <= 2'd0;
      slot[0] <= '0;
      slot[1] <= '0;
    end else begin
      if (push) begin
        slot[wr_ptr] <= push_entry;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Empty queue presents zeros so decode never sees a stale entry.
  assign head = (count != 2'd0) ? slot[rd_ptr] : '0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, in-flight tracking, run/halt FSM and decode queue.
// Optional HALT opcode support is enabled by defining FETCH_HALT_EN.
//
// state      | meaning
// FETCH_RUN  | issuing fetches whenever queue + in-flight has room
// FETCH_HALT | HALT transferred; no fetches, queue empty, wait for redirect
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
  input logic          clk,
  input logic          reset_n,
  fetch_unit_if.master bus
);

  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight;
  logic              armed;
  logic [1:0]        occupancy;
  fetch_entry_t      head;
  fetch_entry_t      push_entry;
  logic              pop;
  logic              push;
  logic              flush;
  logic              issue;
  logic              halt_take;

  assign bus.instr_valid = (occupancy != 2'd0);
  assign bus.instr       = head.instr;
  assign bus.instr_pc    = head.pc;
  assign bus.imem_en     = issue;
  assign bus.imem_addr   = pc;
  assign pop             = bus.instr_valid & bus.instr_ready;
  assign push_entry      = '{pc: inflight_pc, instr: bus.imem_rdata};

`ifdef FETCH_HALT_EN
  assign halt_take  = pop & is_halt(head.instr);
  assign bus.halted = (state == FETCH_HALT);
`else
  assign halt_take  = 1'b0;
  assign bus.halted = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    flush     = 1'b0;
    push      = 1'b0;
    unique case (state)
      FETCH_RUN: begin
        if (bus.redirect_valid) begin
          flush = 1'b1;
        end else if (halt_take) begin
          state_nxt = FETCH_HALT;
          flush     = 1'b1;
        end else begin
          push  = inflight;
          issue = armed &&
                  (({1'b0, occupancy} + {2'b00, inflight} - {2'b00, pop}) < 3'd2);
        end
      end
      FETCH_HALT: begin
        flush = 1'b1;
        if (bus.redirect_valid) begin
          state_nxt = FETCH_RUN;
        end
      end
    endcase
  end

  // inflight follows issue, so a redirect or halt squashes the pending response by clearing it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= FETCH_RUN;
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      armed       <= 1'b0;
    end else begin
      state    <= state_nxt;
      armed    <= 1'b1;
      inflight <= issue;
      if (issue) begin
        inflight_pc <= pc;
      end
      if (bus.redirect_valid) begin
        pc <= bus.redirect_pc;
      end else if (issue) begin
        pc <= pc + ADDR_W'(1);
      end
    end
  end

  fetch_queue u_queue (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (push),
    .pop        (pop),
    .flush      (flush),
    .push_entry (push_entry),
    .head       (head),
    .count      (occupancy)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming, backpressure, redirect, wrap, halt, mid-run reset.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  logic [7:0] mem [256];
  int n_checks = 0;
  int n_fail = 0;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(8'h00)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.imem_en) bus.imem_rdata <= mem[bus.imem_addr];
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic rdy, input logic rv, input logic [7:0] rpc);
    @(negedge clk);
    bus.instr_ready    = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    #1;
  endtask

  task automatic start_run();
    bus.instr_ready    = 1'b1;
    bus.redirect_valid = 1'b0;
    reset_n            = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    step(1'b1, 1'b0, 8'h00);
  endtask

  task automatic chk_head(input string tag, input logic [7:0] ins, input logic [7:0] pc);
    chk({tag, "_valid"}, 16'(bus.instr_valid), 16'h1);
    chk({tag, "_instr"}, 16'(bus.instr), 16'(ins));
    chk({tag, "_pc"},    16'(bus.instr_pc), 16'(pc));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i & 8'h7F);
    mem[8'h00] = 8'h12;
    mem[8'h01] = 8'h15;
    mem[8'h02] = 8'h23;
    mem[8'h05] = 8'hF0;
    bus.imem_rdata     = 8'h00;
    bus.instr_ready    = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 8'h00;
    reset_n            = 1'b0;

    // reset values
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    chk("rst_en",     16'(bus.imem_en), 16'h0);
    chk("rst_addr",   16'(bus.imem_addr), 16'h00);
    chk("rst_valid",  16'(bus.instr_valid), 16'h0);
    chk("rst_instr",  16'(bus.instr), 16'h00);
    chk("rst_pc",     16'(bus.instr_pc), 16'h00);
    chk("rst_halted", 16'(bus.halted), 16'h0);

    // streaming from reset
    reset_n = 1'b1;
    step(1'b1, 1'b0, 8'h00);
    chk("t0_en", 16'(bus.imem_en), 16'h1);
    chk("t0_addr", 16'(bus.imem_addr), 16'h00);
    step(1'b1, 1'b0, 8'h00);
    chk("t1_addr", 16'(bus.imem_addr), 16'h01);
    chk("t1_valid", 16'(bus.instr_valid), 16'h0);
    step(1'b1, 1'b0, 8'h00);
    chk("t2_addr", 16'(bus.imem_addr), 16'h02);
    chk_head("t2", 8'h12, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    chk_head("t3", 8'h15, 8'h01);
    step(1'b1, 1'b0, 8'h00);
    chk_head("t4", 8'h23, 8'h02);

    // backpressure for 5 cycles from T2
    start_run();
    step(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, 8'h00);
      chk("bp_en", 16'(bus.imem_en), 16'h0);
      chk_head("bp_hold", 8'h12, 8'h00);
    end
    step(1'b1, 1'b0, 8'h00);
    chk("bp_rel_en", 16'(bus.imem_en), 16'h1);
    chk("bp_rel_addr", 16'(bus.imem_addr), 16'h02);
    chk_head("bp_r0", 8'h12, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    chk_head("bp_r1", 8'h15, 8'h01);
    step(1'b1, 1'b0, 8'h00);
    chk_head("bp_r2", 8'h23, 8'h02);
    step(1'b1, 1'b0, 8'h00);
    chk_head("bp_r3", 8'h03, 8'h03);

    // redirect to 40 with an entry queued and one response in flight
    start_run();
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h40);
    chk("rd_r_en", 16'(bus.imem_en), 16'h0);
    step(1'b1, 1'b0, 8'h00);
    chk("rd_r1_en", 16'(bus.imem_en), 16'h1);
    chk("rd_r1_addr", 16'(bus.imem_addr), 16'h40);
    chk("rd_r1_valid", 16'(bus.instr_valid), 16'h0);
    step(1'b1, 1'b0, 8'h00);
    chk("rd_r2_addr", 16'(bus.imem_addr), 16'h41);
    chk("rd_r2_valid", 16'(bus.instr_valid), 16'h0);
    step(1'b1, 1'b0, 8'h00);
    chk_head("rd_r3", 8'h40, 8'h40);
    step(1'b1, 1'b0, 8'h00);
    chk_head("rd_r4", 8'h41, 8'h41);

    // wrap through FF
    step(1'b1, 1'b1, 8'hFE);
    chk("wr_r_en", 16'(bus.imem_en), 16'h0);
    step(1'b1, 1'b0, 8'h00);
    chk("wr_a0", 16'(bus.imem_addr), 16'hFE);
    step(1'b1, 1'b0, 8'h00);
    chk("wr_a1", 16'(bus.imem_addr), 16'hFF);
    step(1'b1, 1'b0, 8'h00);
    chk("wr_a2", 16'(bus.imem_addr), 16'h00);
    chk_head("wr_h0", 8'h7E, 8'hFE);
    step(1'b1, 1'b0, 8'h00);
    chk("wr_a3", 16'(bus.imem_addr), 16'h01);
    chk_head("wr_h1", 8'h7F, 8'hFF);
    step(1'b1, 1'b0, 8'h00);
    chk_head("wr_h2", 8'h12, 8'h00);

    // opcode F at PC 05
    start_run();
    repeat (7) step(1'b1, 1'b0, 8'h00);
    chk_head("f_t7", 8'hF0, 8'h05);
    step(1'b1, 1'b0, 8'h00);
`ifdef FETCH_HALT_EN
    chk("h_halted", 16'(bus.halted), 16'h1);
    chk("h_en", 16'(bus.imem_en), 16'h0);
    chk("h_valid", 16'(bus.instr_valid), 16'h0);
    step(1'b1, 1'b1, 8'h00);
    chk("h_r_halted", 16'(bus.halted), 16'h1);
    chk("h_r_en", 16'(bus.imem_en), 16'h0);
    step(1'b1, 1'b0, 8'h00);
    chk("h_r1_halted", 16'(bus.halted), 16'h0);
    chk("h_r1_en", 16'(bus.imem_en), 16'h1);
    chk("h_r1_addr", 16'(bus.imem_addr), 16'h00);
    step(1'b1, 1'b0, 8'h00);
    chk("h_r2_valid", 16'(bus.instr_valid), 16'h0);
    step(1'b1, 1'b0, 8'h00);
    chk_head("h_r3", 8'h12, 8'h00);
`else
    chk("nh_halted", 16'(bus.halted), 16'h0);
    chk("nh_en", 16'(bus.imem_en), 16'h1);
    chk_head("nh_t8", 8'h06, 8'h06);
`endif

    // reset asserted with the queue full
    start_run();
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    chk("mr_full_en", 16'(bus.imem_en), 16'h0);
    chk_head("mr_full", 8'h12, 8'h00);
    reset_n = 1'b0;
    step(1'b0, 1'b0, 8'h00);
    chk("mr_valid", 16'(bus.instr_valid), 16'h0);
    chk("mr_en", 16'(bus.imem_en), 16'h0);
    chk("mr_addr", 16'(bus.imem_addr), 16'h00);
    chk("mr_instr", 16'(bus.instr), 16'h00);
    reset_n = 1'b1;
    step(1'b1, 1'b0, 8'h00);
    chk("mr_t0_en", 16'(bus.imem_en), 16'h1);
    chk("mr_t0_addr", 16'(bus.imem_addr), 16'h00);
    step(1'b1, 1'b0, 8'h00);
    chk("mr_t1_addr", 16'(bus.imem_addr), 16'h01);
    chk("mr_t1_valid", 16'(bus.instr_valid), 16'h0);
    step(1'b1, 1'b0, 8'h00);
    chk_head("mr_t2", 8'h12, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    chk_head("mr_t3", 8'h15, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
